// File: rtl/au_arbiter_if.sv
// Requester-side and AU-side bus of the shared-AU round-robin arbiter.
// Handshake: a requester holds req and its operands; the arbiter raises gnt from ISSUE to RESP and pulses rsp_valid once.
interface au_arbiter_if #(
  parameter int W = 24,
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_r;
  logic [N*W-1:0] req_s;
  logic [N*W-1:0] req_i;
  logic [N*2-1:0] req_op;

  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;

  logic           au_start;
  logic [W-1:0]   au_r;
  logic [W-1:0]   au_s;
  logic [W-1:0]   au_i;
  logic [1:0]     au_ctl_d;
  logic [W-1:0]   au_result;
  logic           au_done;
  logic           au_busy;

  logic [2:0]     fsm_state;

  modport master (
    output req, req_r, req_s, req_i, req_op,
    output au_result, au_done, au_busy,
    input  gnt, rsp_valid, rsp_data, rsp_err,
    input  au_start, au_r, au_s, au_i, au_ctl_d,
    input  fsm_state
  );

  modport slave (
    input  req, req_r, req_s, req_i, req_op,
    input  au_result, au_done, au_busy,
    output gnt, rsp_valid, rsp_data, rsp_err,
    output au_start, au_r, au_s, au_i, au_ctl_d,
    output fsm_state
  );
endinterface

// File: rtl/au_arbiter.sv
// Round-robin scheduler sharing one add/mul/div AU between N requesters,
// with divide-by-zero short-circuit and a bounded wait for AU completion.
module au_arbiter #(
  parameter int W       = 24,
  parameter int N       = 4,
  parameter int TIMEOUT = 63
) (
  input logic        clk,
  input logic        rst,
  au_arbiter_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ZDIV  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gsel;
  logic [PW-1:0] pick;
  logic          found;
  logic          launch;
  logic [CW-1:0] cnt;
  logic          timed_out;

  logic [W-1:0]  pick_r;
  logic [W-1:0]  pick_s;
  logic [W-1:0]  pick_i;
  logic [1:0]    pick_op;
  logic          pick_zdiv;

  logic [W-1:0]  lat_r;
  logic [W-1:0]  lat_s;
  logic [W-1:0]  lat_i;
  logic [1:0]    lat_op;
  logic [W-1:0]  res_data;
  logic          res_err;
  logic [N-1:0]  onehot;

  // First set request at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && bus.req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + i) % N);
      end
    end
  end

  assign pick_r    = bus.req_r[int'(pick) * W +: W];
  assign pick_s    = bus.req_s[int'(pick) * W +: W];
  assign pick_i    = bus.req_i[int'(pick) * W +: W];
  assign pick_op   = bus.req_op[int'(pick) * 2 +: 2];
  assign pick_zdiv = (pick_op == 2'b11) && (pick_s[W-2:0] == '0);
  assign launch    = found && !bus.au_busy;
  assign timed_out = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (launch) nxt_state = pick_zdiv ? ZDIV : ISSUE;
      ISSUE:   nxt_state = WAIT;
      WAIT:    if (bus.au_done || timed_out) nxt_state = RESP;
      ZDIV:    nxt_state = RESP;
      RESP:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // cnt reads 0 during ISSUE and counts ISSUE+WAIT cycles, so an abort
  // reaches RESP exactly TIMEOUT+1 cycles after au_start; done beats timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      gsel     <= '0;
      cnt      <= '0;
      lat_r    <= '0;
      lat_s    <= '0;
      lat_i    <= '0;
      lat_op   <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      case (cur_state)
        IDLE: begin
          cnt <= '0;
          if (launch) begin
            gsel   <= pick;
            lat_r  <= pick_r;
            lat_s  <= pick_s;
            lat_i  <= pick_i;
            lat_op <= pick_op;
          end
        end
        ISSUE: cnt <= cnt + 1'b1;
        WAIT: begin
          if (bus.au_done) begin
            res_data <= bus.au_result;
            res_err  <= 1'b0;
          end else if (timed_out) begin
            res_data <= '0;
            res_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ZDIV: begin
          res_data <= {lat_r[W-1] ^ lat_s[W-1], {(W-1){1'b1}}};
          res_err  <= 1'b1;
        end
        RESP: begin
          res_err <= 1'b0;
          ptr     <= (gsel == PW'(N - 1)) ? '0 : gsel + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign onehot        = {{(N-1){1'b0}}, 1'b1} << gsel;
  assign bus.gnt       = (cur_state == IDLE) ? '0 : onehot;
  assign bus.rsp_valid = (cur_state == RESP) ? onehot : '0;
  assign bus.rsp_data  = res_data;
  assign bus.rsp_err   = res_err;
  assign bus.au_start  = (cur_state == ISSUE);
  assign bus.au_r      = lat_r;
  assign bus.au_s      = lat_s;
  assign bus.au_i      = lat_i;
  assign bus.au_ctl_d  = lat_op;
  assign bus.fsm_state = cur_state;
endmodule
